// File: rtl/load_writeback_queue_if.sv
// load_writeback_queue_if: load-result input handshake and register file write port
interface load_writeback_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [2:0]  in_offset;
  logic [63:0] in_data;
  logic        reg_write;
  logic [4:0]  rd_address;
  logic [63:0] write_data;
  modport master (
    output in_valid, in_rd, in_funct3, in_offset, in_data,
    input  in_ready, reg_write, rd_address, write_data
  );
  modport slave (
    input  in_valid, in_rd, in_funct3, in_offset, in_data,
    output in_ready, reg_write, rd_address, write_data
  );
endinterface

// File: rtl/load_writeback_queue.sv
// load_writeback_queue: formats RV64 load results and queues them for the register file write port
module load_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  load_writeback_queue_if.slave bus,
  input  logic [4:0]           rs1_address,
  input  logic [4:0]           rs2_address,
  output logic                 rs1_pending,
  output logic                 rs2_pending,
  output logic [PTR_W:0]       count,
  output logic                 error
);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0] valid;
  logic [4:0]       ent_rd [DEPTH];
  logic [63:0]      ent_data [DEPTH];
  logic [63:0]      shifted, formatted;
  logic             sx, illegal, accept, store, drain;
  // count never exceeds DEPTH, so its top bit alone marks a full queue
  assign bus.in_ready   = !count[PTR_W];
  assign bus.reg_write  = drain;
  assign bus.rd_address = ent_rd[rd_ptr];
  assign bus.write_data = ent_data[rd_ptr];
  always_comb begin
    shifted = bus.in_data >> {bus.in_offset, 3'b000};
    sx = !bus.in_funct3[2];
    formatted = bus.in_funct3[1:0] == 2'd0 ? {{56{sx & shifted[7]}}, shifted[7:0]} :
                bus.in_funct3[1:0] == 2'd1 ? {{48{sx & shifted[15]}}, shifted[15:0]} :
                bus.in_funct3[1:0] == 2'd2 ? {{32{sx & shifted[31]}}, shifted[31:0]} : bus.in_data;
    illegal = (bus.in_funct3 == 3'b111) ||
              (bus.in_funct3[1:0] == 2'd1 && bus.in_offset[0]) ||
              (bus.in_funct3[1:0] == 2'd2 && bus.in_offset[1:0] != 2'd0) ||
              (bus.in_funct3 == 3'b011 && bus.in_offset != 3'd0);
    accept = bus.in_valid && bus.in_ready;
    store = accept && !illegal && bus.in_rd != 5'd0;
    drain = count != '0;
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_pending = rs1_pending | (valid[i] && rs1_address != 5'd0 && ent_rd[i] == rs1_address);
      rs2_pending = rs2_pending | (valid[i] && rs2_address != 5'd0 && ent_rd[i] == rs2_address);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      error  <= 1'b0;
    end else begin
      error <= accept && illegal;
      if (drain) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (store) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      count <= count + (PTR_W+1)'(store) - (PTR_W+1)'(drain);
    end
  end
  always_ff @(posedge clock) begin
    if (store) begin
      ent_rd[wr_ptr]   <= bus.in_rd;
      ent_data[wr_ptr] <= formatted;
    end
  end
endmodule

// File: doc/load_writeback_queue.md
Name: load_writeback_queue

Overview:
- Sits between the data-memory read path and the register file's single write port.
- Formats raw 64-bit memory words into RV64 load results: byte/half/word/double extraction by byte offset, with sign or zero extension.
- Buffers formatted results in a small FIFO and drains one per cycle into the register file write port.
- Exposes a pending-write scoreboard so issue logic can stall on read-after-write hazards against queued loads.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  load result offered
- in_ready  output  1  queue can accept this cycle
- in_rd  input  5  destination register
- in_funct3  input  3  RV64 load funct3 (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU)
- in_offset  input  3  byte offset of the access within the 64-bit word
- in_data  input  64  raw memory word, little-endian
- reg_write  output  1  write enable to the register file
- rd_address  output  5  register file write address
- write_data  output  64  register file write data
- rs1_address  input  5  issue-side source 1
- rs2_address  input  5  issue-side source 2
- rs1_pending  output  1  rs1 has a queued write
- rs2_pending  output  1  rs2 has a queued write
- count  output  PTR_W+1  occupied entries
- error  output  1  one-cycle pulse on an illegal or misaligned load

Behaviour:
- Reset (synchronous, active-high): rd/wr pointers=0, count=0, all entry valid bits=0, error=0.
  - Consequently reg_write=0, rs1_pending=0, rs2_pending=0, in_ready=1.
  - Reset mid-operation discards all queued entries; nothing is written in the reset cycle.
- Handshake: in_ready = (count < DEPTH). This depends on the registered count only, not on a same-cycle drain. A transfer occurs when in_valid && in_ready at a rising edge.
- Formatting (combinational, applied at accept time): shifted = in_data >> (8*in_offset).
  - LB/LBU: shifted[7:0], sign- or zero-extended to 64 bits.
  - LH/LHU: shifted[15:0], sign- or zero-extended.
  - LW/LWU: shifted[31:0], sign- or zero-extended.
  - LD: in_data unchanged.
- Alignment rules:
  - LH/LHU require in_offset[0]==0.
  - LW/LWU require in_offset[1:0]==0.
  - LD requires in_offset==0.
  - funct3 111 is illegal.
- Illegal or misaligned transfer: handshake completes, nothing is stored, and error=1 on the following cycle only.
- Transfer with in_rd==0: handshake completes, nothing is stored, no error.
- Storage: a legal transfer with in_rd!=0 writes {rd, data, valid=1} at wr_ptr; wr_ptr increments modulo DEPTH.
- Drain: the register file always accepts, so no backpressure.
  - reg_write = (count != 0).
  - rd_address and write_data are taken combinationally from the head entry.
  - At each edge with count != 0: the head valid bit clears and rd_ptr increments modulo DEPTH.
- Latency: a result accepted at edge N onto an empty queue is presented at reg_write during cycle N+1 and written at edge N+1. There is no bypass from input to output.
- Simultaneous store and drain: count stays unchanged; both pointers advance.
- Pending scoreboard (combinational): rs1_pending = (rs1_address != 0) && (some valid entry has rd == rs1_address); rs2 likewise.
  - Only stored entries are checked; the entry being offered on in_* this cycle is not.
  - The head entry is included up to and including its write cycle.
- Duplicate rd in the queue is allowed. Entries drain in FIFO order, so the last write wins.
- count range is 0..DEPTH. Pointer wrap uses PTR_W-bit natural overflow.
- Outputs rd_address and write_data are don't-care when reg_write=0; they may show stale head contents.

Test Plan:
- Sign/zero extension: in_data=64'h8877_6655_4433_2211, funct3=000, offset=7, rd=5 -> next cycle reg_write=1, rd_address=5, write_data=64'hFFFF_FFFF_FFFF_FF88. Same transfer with funct3=100 -> write_data=64'h0000_0000_0000_0088.
- Word and double loads:
  - in_data=64'h8000_0001_7FFF_FFFF, funct3=010, offset=4 -> write_data=64'hFFFF_FFFF_8000_0001.
  - Same data, funct3=110, offset=0 -> write_data=64'h0000_0000_7FFF_FFFF.
  - LD, offset=0 -> data passes through unchanged.
- Misaligned and x0 transfers:
  - LH at offset=3 -> error=1 for exactly one cycle, count stays 0, no reg_write.
  - funct3=111 -> same response.
  - LD with rd=0 -> no error, no write.
- Full and backpressure: hold reg_write draining while offering 6 back-to-back transfers with rd=1..6 from empty.
  - Queue never exceeds count=DEPTH.
  - in_ready deasserts only when count=4.
  - All 6 writes emerge in order rd=1..6, one per cycle, with no loss or duplication.
- Scoreboard: queue entries with rd=7 and rd=9, set rs1_address=9, rs2_address=0.
  - rs1_pending=1 and rs2_pending=0 until the rd=9 write cycle completes, then rs1_pending=0.
  - rs1_address=3 with no matching entry -> rs1_pending=0.
- Reset mid-operation: with count=3, assert reset for one cycle -> next cycle count=0, reg_write=0, both pending outputs=0, in_ready=1, no stale write afterwards.
